// File: rtl/hilo_div_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : hilo_div_ctrl_if
//  Brief    : EX-side issue, DIV unit launch/result and HI/LO result bundle
//             for the HI/LO divide controller.
//  Revision : 1.0  initial release
// ============================================================================
interface hilo_div_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             flush;
    logic             issue_valid;
    logic [2:0]       issue_op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic [WIDTH-1:0] div_quotient;
    logic [WIDTH-1:0] div_remainder;
    logic             div_start;
    logic             div_signed;
    logic [WIDTH-1:0] div_dividend;
    logic [WIDTH-1:0] div_divisor;
    logic             stall_req;
    logic             busy;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] mf_data;
    logic             mf_valid;
    logic             done;

    // Driver side: EX pipeline plus the DIV unit result path
    modport master (
        output flush, issue_valid, issue_op, src_a, src_b,
               div_quotient, div_remainder,
        input  div_start, div_signed, div_dividend, div_divisor,
               stall_req, busy, hi, lo, mf_data, mf_valid, done
    );

    modport slave (
        input  flush, issue_valid, issue_op, src_a, src_b,
               div_quotient, div_remainder,
        output div_start, div_signed, div_dividend, div_divisor,
               stall_req, busy, hi, lo, mf_data, mf_valid, done
    );
endinterface
`default_nettype wire

// File: rtl/hilo_div_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : hilo_div_ctrl
//  Brief    : Issues one divide at a time to a fixed-latency DIV unit, owns the
//             architectural HI/LO registers and stalls EX while a divide runs.
//  Revision : 1.0  initial release
// ============================================================================
module hilo_div_ctrl #(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 16
) (
    input  logic                clk,
    input  logic                reset,
    hilo_div_ctrl_if.slave      bus
);

    localparam int         c_CNT_W    = (LATENCY > 2) ? $clog2(LATENCY) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(LATENCY - 1);

    localparam logic [2:0] c_OP_NOP0 = 3'd0;
    localparam logic [2:0] c_OP_DIV  = 3'd1;
    localparam logic [2:0] c_OP_DIVU = 3'd2;
    localparam logic [2:0] c_OP_MTHI = 3'd3;
    localparam logic [2:0] c_OP_MTLO = 3'd4;
    localparam logic [2:0] c_OP_MFHI = 3'd5;
    localparam logic [2:0] c_OP_MFLO = 3'd6;
    localparam logic [2:0] c_OP_NOP7 = 3'd7;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_WB   = 2'd2;

    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_mf_data;
    logic [WIDTH-1:0]   r_dividend;
    logic [WIDTH-1:0]   r_divisor;
    logic               r_div_start;
    logic               r_div_signed;
    logic               r_mf_valid;
    logic               r_done;

    logic               w_busy;
    logic               w_op_real;

    assign w_busy    = (r_state != c_ST_IDLE);
    assign w_op_real = (bus.issue_op != c_OP_NOP0) && (bus.issue_op != c_OP_NOP7);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_ST_IDLE;
            r_cnt        <= '0;
            r_hi         <= '0;
            r_lo         <= '0;
            r_mf_data    <= '0;
            r_dividend   <= '0;
            r_divisor    <= '0;
            r_div_start  <= 1'b0;
            r_div_signed <= 1'b0;
            r_mf_valid   <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_div_start <= 1'b0;
            r_mf_valid  <= 1'b0;
            r_done      <= 1'b0;
            if (bus.flush) begin
                // Drops the presented op and any in-flight divide; HI/LO keep their values
                r_state <= c_ST_IDLE;
                r_cnt   <= '0;
            end else begin
                case (r_state)
                    c_ST_IDLE: begin
                        if (bus.issue_valid) begin
                            case (bus.issue_op)
                                c_OP_DIV, c_OP_DIVU: begin
                                    if (bus.src_b != '0) begin
                                        r_div_start  <= 1'b1;
                                        r_div_signed <= (bus.issue_op == c_OP_DIV);
                                        r_dividend   <= bus.src_a;
                                        r_divisor    <= bus.src_b;
                                        r_cnt        <= c_CNT_LOAD;
                                        r_state      <= c_ST_RUN;
                                    end else begin
                                        // Divide by zero completes immediately, HI/LO untouched
                                        r_done <= 1'b1;
                                    end
                                end
                                c_OP_MTHI: r_hi <= bus.src_a;
                                c_OP_MTLO: r_lo <= bus.src_a;
                                c_OP_MFHI: begin
                                    r_mf_data  <= r_hi;
                                    r_mf_valid <= 1'b1;
                                end
                                c_OP_MFLO: begin
                                    r_mf_data  <= r_lo;
                                    r_mf_valid <= 1'b1;
                                end
                                default: ;
                            endcase
                        end
                    end
                    c_ST_RUN: begin
                        if (r_cnt == '0) begin
                            r_state <= c_ST_WB;
                        end else begin
                            r_cnt <= r_cnt - 1'b1;
                        end
                    end
                    c_ST_WB: begin
                        r_lo    <= bus.div_quotient;
                        r_hi    <= bus.div_remainder;
                        r_done  <= 1'b1;
                        r_state <= c_ST_IDLE;
                    end
                    default: begin
                        r_state <= c_ST_IDLE;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.stall_req    = bus.issue_valid && w_busy && w_op_real;
    assign bus.busy         = w_busy;
    assign bus.div_start    = r_div_start;
    assign bus.div_signed   = r_div_signed;
    assign bus.div_dividend = r_dividend;
    assign bus.div_divisor  = r_divisor;
    assign bus.hi           = r_hi;
    assign bus.lo           = r_lo;
    assign bus.mf_data      = r_mf_data;
    assign bus.mf_valid     = r_mf_valid;
    assign bus.done         = r_done;

endmodule
`default_nettype wire

// File: tb/tb_hilo_div_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hilo_div_ctrl
//  Brief    : Directed scoreboard bench for hilo_div_ctrl with a fixed-latency
//             DIV unit stand-in.
//  Revision : 1.0  initial release
// ============================================================================
module tb_hilo_div_ctrl;

    localparam int WIDTH   = 32;
    localparam int LATENCY = 16;

    localparam logic [2:0] OP_DIV  = 3'd1;
    localparam logic [2:0] OP_DIVU = 3'd2;
    localparam logic [2:0] OP_MTHI = 3'd3;
    localparam logic [2:0] OP_MFHI = 3'd5;
    localparam logic [2:0] OP_MFLO = 3'd6;

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;

    hilo_div_ctrl_if #(.WIDTH(WIDTH)) bus ();

    hilo_div_ctrl #(.WIDTH(WIDTH), .LATENCY(LATENCY)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          is_done;
        int          at_cyc;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc, act, req);
        end
    endtask

    function automatic exp_t mk(input bit d, input int c, input logic [31:0] h,
                                input logic [31:0] l, input logic [31:0] dt);
        exp_t e;
        e.is_done = d; e.at_cyc = c; e.hi = h; e.lo = l; e.data = dt;
        return e;
    endfunction

    // DIV unit stand-in: correct result only in the cycle LATENCY after div_start
    int          age = 0;
    logic        m_sgn;
    logic [31:0] m_a, m_b;
    always @(negedge clk) begin
        if (bus.div_start === 1'b1) begin
            age = 1; m_sgn = bus.div_signed; m_a = bus.div_dividend; m_b = bus.div_divisor;
        end else if (age > 0) begin
            age++;
        end
        if (age == LATENCY + 1 && m_b != 0) begin
            if (m_sgn) begin
                bus.div_quotient  = $signed(m_a) / $signed(m_b);
                bus.div_remainder = $signed(m_a) % $signed(m_b);
            end else begin
                bus.div_quotient  = m_a / m_b;
                bus.div_remainder = m_a % m_b;
            end
        end else begin
            bus.div_quotient  = 32'hBAD0_0000 + age;
            bus.div_remainder = 32'hBAD1_0000 + age;
        end
    end

    // Monitor: every done / mf_valid pulse must match the head of the queue
    always @(negedge clk) begin
        if (bus.done === 1'b1 || bus.mf_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", {30'd0, bus.done, bus.mf_valid}, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("pulse_cycle", cyc, e.at_cyc);
                if (e.is_done) begin
                    chk("done", {31'd0, bus.done}, 32'd1);
                    chk("wb_hi", bus.hi, e.hi);
                    chk("wb_lo", bus.lo, e.lo);
                end else begin
                    chk("mf_valid", {31'd0, bus.mf_valid}, 32'd1);
                    chk("mf_data", bus.mf_data, e.data);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.issue_valid = 1'b1; bus.issue_op = op; bus.src_a = a; bus.src_b = b;
        tick();
        bus.issue_valid = 1'b0; bus.issue_op = 3'd0;
    endtask

    initial begin
        int t;
        reset = 1'b1;
        bus.flush = 1'b0; bus.issue_valid = 1'b0; bus.issue_op = 3'd0;
        bus.src_a = '0; bus.src_b = '0;
        bus.div_quotient = '0; bus.div_remainder = '0;
        repeat (3) tick();
        reset = 1'b0;

        // Reset then idle
        chk("rst_hi", bus.hi, 32'd0);
        chk("rst_lo", bus.lo, 32'd0);
        for (int k = 0; k < 20; k++) begin
            chk("idle_flags", {27'd0, bus.busy, bus.div_start, bus.done, bus.mf_valid, bus.stall_req}, 32'd0);
            tick();
        end

        // DIVU 100/7
        t = cyc;
        exp_q.push_back(mk(1'b1, t + 18, 32'd2, 32'd14, 32'd0));
        issue(OP_DIVU, 32'd100, 32'd7);
        chk("divu_start", {31'd0, bus.div_start}, 32'd1);
        chk("divu_signed", {31'd0, bus.div_signed}, 32'd0);
        chk("divu_dividend", bus.div_dividend, 32'd100);
        chk("divu_divisor", bus.div_divisor, 32'd7);
        chk("divu_busy_first", {31'd0, bus.busy}, 32'd1);
        for (int k = 2; k <= 18; k++) begin
            tick();
            chk("divu_busy", {31'd0, bus.busy}, (k <= 17) ? 32'd1 : 32'd0);
            chk("divu_start_low", {31'd0, bus.div_start}, 32'd0);
        end
        chk("divu_hi", bus.hi, 32'd2);
        chk("divu_lo", bus.lo, 32'd14);

        // DIV -7/2 with a stalled MFLO
        t = cyc;
        exp_q.push_back(mk(1'b1, t + 18, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd0));
        exp_q.push_back(mk(1'b0, t + 19, 32'd0, 32'd0, 32'hFFFF_FFFD));
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        chk("div_signed", {31'd0, bus.div_signed}, 32'd1);
        repeat (4) tick();
        bus.issue_valid = 1'b1; bus.issue_op = OP_MFLO;
        for (int c = t + 5; c <= t + 18; c++) begin
            #1;
            chk("mflo_stall", {31'd0, bus.stall_req}, (c <= t + 17) ? 32'd1 : 32'd0);
            tick();
        end
        bus.issue_valid = 1'b0; bus.issue_op = 3'd0;
        chk("div_lo", bus.lo, 32'hFFFF_FFFD);
        chk("div_hi", bus.hi, 32'hFFFF_FFFF);
        repeat (2) tick();

        // MTHI then MFHI
        t = cyc;
        exp_q.push_back(mk(1'b0, t + 2, 32'd0, 32'd0, 32'hDEAD_BEEF));
        issue(OP_MTHI, 32'hDEAD_BEEF, 32'd0);
        issue(OP_MFHI, 32'd0, 32'd0);
        chk("mthi_hi", bus.hi, 32'hDEAD_BEEF);
        repeat (3) tick();

        // DIVU by zero
        t = cyc;
        exp_q.push_back(mk(1'b1, t + 1, 32'hDEAD_BEEF, 32'hFFFF_FFFD, 32'd0));
        issue(OP_DIVU, 32'd55, 32'd0);
        for (int k = 0; k < 5; k++) begin
            chk("div0_quiet", {30'd0, bus.busy, bus.div_start}, 32'd0);
            tick();
        end
        chk("div0_hi", bus.hi, 32'hDEAD_BEEF);
        chk("div0_lo", bus.lo, 32'hFFFF_FFFD);

        // DIVU 9/3 flushed at T+10, then a new DIV at T+12
        t = cyc;
        issue(OP_DIVU, 32'd9, 32'd3);
        repeat (9) tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("flush_busy", {31'd0, bus.busy}, 32'd0);
        chk("flush_cyc", cyc, t + 11);
        chk("flush_hi", bus.hi, 32'hDEAD_BEEF);
        chk("flush_lo", bus.lo, 32'hFFFF_FFFD);
        tick();
        t = cyc;
        exp_q.push_back(mk(1'b1, t + 18, 32'd2, 32'hFFFF_FFF2, 32'd0));
        issue(OP_DIV, 32'd100, 32'hFFFF_FFF9);
        repeat (17) tick();
        chk("post_flush_lo", bus.lo, 32'hFFFF_FFF2);
        chk("post_flush_hi", bus.hi, 32'd2);

        // Flush during WB cancels the capture
        t = cyc;
        issue(OP_DIVU, 32'd50, 32'd5);
        repeat (16) tick();
        chk("wb_busy", {31'd0, bus.busy}, 32'd1);
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("wbflush_busy", {31'd0, bus.busy}, 32'd0);
        repeat (3) tick();
        chk("wbflush_hi", bus.hi, 32'd2);
        chk("wbflush_lo", bus.lo, 32'hFFFF_FFF2);

        // Reset mid-divide
        issue(OP_DIVU, 32'd100, 32'd7);
        repeat (7) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int k = 0; k < 25; k++) begin
            chk("rst_mid_busy", {31'd0, bus.busy}, 32'd0);
            tick();
        end
        chk("rst_mid_hi", bus.hi, 32'd0);
        chk("rst_mid_lo", bus.lo, 32'd0);

        repeat (3) tick();
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
